cache_write_arbiter: RTL and testbench
======================================

// Module: cache_write_arbiter
// PURPOSE
//  Arbitrates and sequences all writes into the cache data ways, between two requesters:
//   - CPU store path, buffered in an internal FIFO;
//   - line-refill path, which writes a burst of words.
//  Drives a registered one-hot target way plus write data into the way-write datapath.
//  Holds a refill burst atomically and bounds CPU-store starvation with a stall counter.
// PARAMETERS
//  NUM_WAYS    4   number of cache ways; width of all one-hot way vectors
//  DATA_WIDTH  32  write data width
//  BUF_DEPTH   4   store FIFO entries; power of 2, >= 2
//  MAX_STALL   8   cycles a pending store may wait before forced grant; >= 1
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst_n          in   1           asynchronous active-low reset
//  st_valid       in   1           CPU store request
//  st_ready       out  1           store accepted when st_valid && st_ready
//  st_way         in   NUM_WAYS    one-hot target way of store
//  st_data        in   DATA_WIDTH  store data
//  fl_valid       in   1           refill word valid
//  fl_ready       out  1           refill word accepted when fl_valid && fl_ready
//  fl_way         in   NUM_WAYS    one-hot target way of refill
//  fl_data        in   DATA_WIDTH  refill word
//  fl_last        in   1           final word of refill burst
//  wr_target_way  out  NUM_WAYS    one-hot way write enable to way datapath (registered)
//  wr_data        out  DATA_WIDTH  write data to way datapath (registered)
//  busy           out  1           FSM != IDLE or FIFO non-empty
//  way_err        out  1           1-cycle pulse: rejected non-one-hot way
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE; FIFO empty; stall_cnt=0; all outputs 0.
//  FIFO: st_ready = !full.
//   - Push on st_valid && st_ready. A push when st_way is not one-hot is dropped and
//     way_err pulses the next cycle.
//   - Push at full is impossible, even while a pop occurs that cycle.
//   - No bypass: a store reaches wr_* no earlier than 2 cycles after acceptance.
//  FSM states:
//   - IDLE:
//     - Grant fill if fl_valid && (stall_cnt < MAX_STALL || FIFO empty).
//     - Otherwise grant store if FIFO non-empty.
//     - A fill grant with !fl_last moves to FILL. A store grant pops one entry and stays in IDLE.
//   - FILL:
//     - fl_ready=1; the store path is not granted.
//     - Each accepted word is written.
//     - Return to IDLE on an accepted word with fl_last=1.
//     - fl_valid low mid-burst: hold in FILL, write nothing.
//  fl_ready: 1 in FILL. In IDLE, 1 exactly when the fill-grant condition holds.
//  stall_cnt:
//   - +1 each cycle FIFO non-empty and no store granted; saturates at MAX_STALL.
//   - Clears on store grant.
//   - A forced store (stall_cnt==MAX_STALL) only takes effect in IDLE; an open burst finishes first.
//  Outputs:
//   - The cycle after a grant: wr_target_way = granted way, wr_data = granted data.
//   - Otherwise both are 0. At most one bit of wr_target_way is ever set.
//  fl_way is not checked (the refill engine guarantees one-hot). Non-one-hot fl_way is a bench error.
//  Reset mid-burst: burst is abandoned, FIFO flushed; the requester must restart the refill.
// CONFIGURATION
//  CACHE_WR_ARB_STATS_EN defined:
//   - Adds outputs stat_store_cnt [15:0], stat_fill_cnt [15:0], stat_force_cnt [15:0].
//   - They count store writes, fill words and forced store grants.
//   - Saturating; cleared by rst_n.
//  Not defined: these ports and counters are absent; other behaviour identical.
// TESTING
//  1 Single store way=4'b0010 data=0xA5A5_0001, no fill
//    -> wr_target_way=0010 and wr_data=0xA5A5_0001 for one cycle, 2 cycles after accept.
//  2 Fill burst of 4 words (way 4'b1000, fl_last on 4th) with a store pending
//    -> 4 fill writes back-to-back, then the store write; store never interleaves.
//  3 Fill valid every cycle in single-word bursts, one store pushed, MAX_STALL=8
//    -> store written exactly once stall_cnt reaches 8; counter then reads 0.
//  4 Push 5 stores back-to-back, BUF_DEPTH=4, fill active
//    -> st_ready drops after the 4th; all 4 drain in FIFO order; no loss, no duplicate.
//  5 Store with st_way=4'b0110 -> no write, way_err pulses 1 cycle, FIFO count unchanged.
//  6 Assert rst_n low mid-burst -> all outputs 0 immediately, busy=0, FIFO empty;
//    new burst after release accepted normally.

Source files
------------

// File: rtl/cache_write_arbiter.sv
// Cache way-write arbiter: buffered CPU stores vs. atomic refill bursts, with a starvation bound.
// Optional statistics counters are enabled by defining CACHE_WR_ARB_STATS_EN.
module cache_write_arbiter #(
   parameter int NUM_WAYS   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 4,
   parameter int MAX_STALL  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [NUM_WAYS-1:0]   st_way,
   input  logic [DATA_WIDTH-1:0] st_data,
   input  logic                  fl_valid,
   output logic                  fl_ready,
   input  logic [NUM_WAYS-1:0]   fl_way,
   input  logic [DATA_WIDTH-1:0] fl_data,
   input  logic                  fl_last,
   output logic [NUM_WAYS-1:0]   wr_target_way,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  way_err
`ifdef CACHE_WR_ARB_STATS_EN
   ,
   output logic [15:0]           stat_store_cnt,
   output logic [15:0]           stat_fill_cnt,
   output logic [15:0]           stat_force_cnt
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(MAX_STALL + 1);

   typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

   state_t                  state_r;
   logic [NUM_WAYS-1:0]     way_mem_r  [BUF_DEPTH];
   logic [DATA_WIDTH-1:0]   data_mem_r [BUF_DEPTH];
   logic [PW-1:0]           wr_ptr_r;
   logic [PW-1:0]           rd_ptr_r;
   logic [CW-1:0]           count_r;
   logic [SW-1:0]           stall_cnt_r;
   logic [NUM_WAYS-1:0]     wr_way_r;
   logic [DATA_WIDTH-1:0]   wr_data_r;
   logic                    way_err_r;

   logic empty_s, full_s, way_ok_s, push_s, bad_way_s, fill_ok_s;
   logic fill_grant_s, store_grant_s, forced_s;

   function automatic logic is_onehot(input logic [NUM_WAYS-1:0] v);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < NUM_WAYS; i++) n += {31'd0, v[i]};
      return (n == 32'd1);
   endfunction

   assign empty_s   = (count_r == {CW{1'b0}});
   assign full_s    = (count_r == CW'(BUF_DEPTH));
   assign way_ok_s  = is_onehot(st_way);
   assign st_ready  = !full_s;
   assign push_s    = st_valid && st_ready && way_ok_s;
   assign bad_way_s = st_valid && st_ready && !way_ok_s;
   // Fill wins in IDLE unless a buffered store has waited MAX_STALL cycles.
   assign fill_ok_s = fl_valid && ((stall_cnt_r < SW'(MAX_STALL)) || empty_s);
   assign forced_s  = store_grant_s && (stall_cnt_r == SW'(MAX_STALL));

   // Grant selection for the current cycle.
   always_comb begin
      fill_grant_s  = 1'b0;
      store_grant_s = 1'b0;
      fl_ready      = 1'b0;
      case (state_r)
         IDLE: begin
            fl_ready = fill_ok_s;
            if (fill_ok_s) begin
               fill_grant_s = 1'b1;
            end else if (!empty_s) begin
               store_grant_s = 1'b1;
            end else begin
               store_grant_s = 1'b0;
            end
         end
         FILL: begin
            fl_ready     = 1'b1;
            fill_grant_s = fl_valid;
         end
         default: begin
            fl_ready = 1'b0;
         end
      endcase
   end

   // Store FIFO storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < BUF_DEPTH; i++) begin
            way_mem_r[i]  <= {NUM_WAYS{1'b0}};
            data_mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         if (push_s) begin
            way_mem_r[wr_ptr_r]  <= st_way;
            data_mem_r[wr_ptr_r] <= st_data;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         if (store_grant_s) rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({push_s, store_grant_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FSM, starvation counter and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         stall_cnt_r <= {SW{1'b0}};
         wr_way_r    <= {NUM_WAYS{1'b0}};
         wr_data_r   <= {DATA_WIDTH{1'b0}};
         way_err_r   <= 1'b0;
      end else begin
         way_err_r <= bad_way_s;
         case (state_r)
            IDLE:    if (fill_grant_s && !fl_last) state_r <= FILL;
            FILL:    if (fl_valid && fl_last) state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
         if (store_grant_s) begin
            stall_cnt_r <= {SW{1'b0}};
         end else if (!empty_s && (stall_cnt_r < SW'(MAX_STALL))) begin
            stall_cnt_r <= stall_cnt_r + SW'(1);
         end
         if (fill_grant_s) begin
            wr_way_r  <= fl_way;
            wr_data_r <= fl_data;
         end else if (store_grant_s) begin
            wr_way_r  <= way_mem_r[rd_ptr_r];
            wr_data_r <= data_mem_r[rd_ptr_r];
         end else begin
            wr_way_r  <= {NUM_WAYS{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
         end
      end
   end

   assign wr_target_way = wr_way_r;
   assign wr_data       = wr_data_r;
   assign way_err       = way_err_r;
   assign busy          = (state_r != IDLE) || !empty_s;

`ifdef CACHE_WR_ARB_STATS_EN
   logic [15:0] stat_store_r, stat_fill_r, stat_force_r;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_store_r <= 16'd0;
         stat_fill_r  <= 16'd0;
         stat_force_r <= 16'd0;
      end else begin
         if (store_grant_s && (stat_store_r != 16'hFFFF)) stat_store_r <= stat_store_r + 16'd1;
         if (fill_grant_s && (stat_fill_r != 16'hFFFF))   stat_fill_r  <= stat_fill_r + 16'd1;
         if (forced_s && (stat_force_r != 16'hFFFF))      stat_force_r <= stat_force_r + 16'd1;
      end
   end

   assign stat_store_cnt = stat_store_r;
   assign stat_fill_cnt  = stat_fill_r;
   assign stat_force_cnt = stat_force_r;
`else
   logic unused_s;
   assign unused_s = forced_s;
`endif

endmodule

// File: tb/tb_cache_write_arbiter.sv
// Directed vector bench for cache_write_arbiter (default build, stats disabled).
module tb_cache_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid, st_ready, fl_valid, fl_ready, fl_last, busy, way_err;
   logic [3:0]  st_way, fl_way, wr_target_way;
   logic [31:0] st_data, fl_data, wr_data;

   int pass_cnt  = 0;
   int total_cnt = 0;

   cache_write_arbiter #(.NUM_WAYS(4), .DATA_WIDTH(32), .BUF_DEPTH(4), .MAX_STALL(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_way(st_way), .st_data(st_data),
      .fl_valid(fl_valid), .fl_ready(fl_ready), .fl_way(fl_way), .fl_data(fl_data),
      .fl_last(fl_last),
      .wr_target_way(wr_target_way), .wr_data(wr_data), .busy(busy), .way_err(way_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sv;
      logic [3:0]  sw;
      logic [31:0] sd;
      logic        fv;
      logic [3:0]  fw;
      logic [31:0] fd;
      logic        fl;
      logic        e_sr;
      logic        e_fr;
      logic [3:0]  e_way;
      logic [31:0] e_data;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic sv, input logic [3:0] sw, input logic [31:0] sd,
                               input logic fv, input logic [3:0] fw, input logic [31:0] fd,
                               input logic fl, input logic e_sr, input logic e_fr,
                               input logic [3:0] e_way, input logic [31:0] e_data,
                               input logic e_busy, input logic e_err);
      vec_t v;
      v.sv = sv; v.sw = sw; v.sd = sd; v.fv = fv; v.fw = fw; v.fd = fd; v.fl = fl;
      v.e_sr = e_sr; v.e_fr = e_fr; v.e_way = e_way; v.e_data = e_data;
      v.e_busy = e_busy; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic sv, input logic [3:0] sw, input logic [31:0] sd,
                        input logic fv, input logic [3:0] fw, input logic [31:0] fd,
                        input logic fl);
      st_valid = sv; st_way = sw; st_data = sd;
      fl_valid = fv; fl_way = fw; fl_data = fd; fl_last = fl;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      drive(v.sv, v.sw, v.sd, v.fv, v.fw, v.fd, v.fl);
      #1;
      chk($sformatf("v%0d st_ready", idx), {31'd0, st_ready}, {31'd0, v.e_sr});
      chk($sformatf("v%0d fl_ready", idx), {31'd0, fl_ready}, {31'd0, v.e_fr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wr_way", idx), {28'd0, wr_target_way}, {28'd0, v.e_way});
      chk($sformatf("v%0d wr_data", idx), wr_data, v.e_data);
      chk($sformatf("v%0d busy", idx), {31'd0, busy}, {31'd0, v.e_busy});
      chk($sformatf("v%0d way_err", idx), {31'd0, way_err}, {31'd0, v.e_err});
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset wr_way", {28'd0, wr_target_way}, 32'd0);
      chk("reset wr_data", wr_data, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset way_err", {31'd0, way_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //                sv   sw     sd            fv   fw     fd            fl   sr   fr   way    data          busy err
      // single store, written two cycles after acceptance
      vq.push_back(mk(1'b1, 4'b0010, 32'hA5A5_0001, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0010, 32'hA5A5_0001, 1'b0, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 1'b0));
      // non-one-hot store way dropped
      vq.push_back(mk(1'b1, 4'b0110, 32'h1234,      1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 1'b1));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 1'b0));
      // burst with a pending store and a mid-burst gap; store waits for the burst end
      vq.push_back(mk(1'b1, 4'b0001, 32'h11,        1'b1, 4'b1000, 32'hF0, 1'b0, 1'b1, 1'b1, 4'b1000, 32'hF0,       1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b1, 4'b1000, 32'hF1, 1'b0, 1'b1, 1'b1, 4'b1000, 32'hF1,       1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b1000, 32'h0,  1'b0, 1'b1, 1'b1, 4'b0000, 32'h0,        1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b1, 4'b1000, 32'hF2, 1'b0, 1'b1, 1'b1, 4'b1000, 32'hF2,       1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b1, 4'b1000, 32'hF3, 1'b1, 1'b1, 1'b1, 4'b1000, 32'hF3,       1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0,  1'b0, 1'b1, 1'b0, 4'b0001, 32'h11,       1'b0, 1'b0));
      // five stores during a burst: FIFO fills, fifth retried, all drain in order
      vq.push_back(mk(1'b1, 4'b0001, 32'h101,       1'b1, 4'b0100, 32'h200, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h200,     1'b1, 1'b0));
      vq.push_back(mk(1'b1, 4'b0010, 32'h102,       1'b1, 4'b0100, 32'h201, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h201,     1'b1, 1'b0));
      vq.push_back(mk(1'b1, 4'b0100, 32'h103,       1'b1, 4'b0100, 32'h202, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h202,     1'b1, 1'b0));
      vq.push_back(mk(1'b1, 4'b1000, 32'h104,       1'b1, 4'b0100, 32'h203, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h203,     1'b1, 1'b0));
      vq.push_back(mk(1'b1, 4'b0001, 32'h105,       1'b1, 4'b0100, 32'h204, 1'b1, 1'b0, 1'b1, 4'b0100, 32'h204,     1'b1, 1'b0));
      vq.push_back(mk(1'b1, 4'b0001, 32'h105,       1'b0, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b0, 4'b0001, 32'h101,     1'b1, 1'b0));
      vq.push_back(mk(1'b1, 4'b0001, 32'h105,       1'b0, 4'b0000, 32'h0,   1'b0, 1'b1, 1'b0, 4'b0010, 32'h102,     1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0,   1'b0, 1'b1, 1'b0, 4'b0100, 32'h103,     1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0,   1'b0, 1'b1, 1'b0, 4'b1000, 32'h104,     1'b1, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0,   1'b0, 1'b1, 1'b0, 4'b0001, 32'h105,     1'b0, 1'b0));
      vq.push_back(mk(1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 32'h0,   1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,       1'b0, 1'b0));

      for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

      // Starvation bound: single-word fills every cycle, one store pushed at cycle 0.
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         drive((c == 0), 4'b0010, 32'h333, 1'b1, 4'b0001, 32'(c), 1'b1);
         #1;
         chk($sformatf("stall c%0d fl_ready", c), {31'd0, fl_ready}, (c == 9) ? 32'd0 : 32'd1);
         @(posedge clk);
         #1;
         if (c == 9) begin
            chk("stall forced way", {28'd0, wr_target_way}, 32'h2);
            chk("stall forced data", wr_data, 32'h333);
         end else begin
            chk($sformatf("stall c%0d way", c), {28'd0, wr_target_way}, 32'h1);
            chk($sformatf("stall c%0d data", c), wr_data, 32'(c));
         end
      end

      // Reset in the middle of a burst with a store buffered.
      @(negedge clk);
      drive(1'b1, 4'b0100, 32'h77, 1'b1, 4'b0010, 32'h55, 1'b0);
      @(posedge clk);
      #1;
      chk("pre-reset way", {28'd0, wr_target_way}, 32'h2);
      chk("pre-reset busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid-reset way", {28'd0, wr_target_way}, 32'd0);
      chk("mid-reset data", wr_data, 32'd0);
      chk("mid-reset busy", {31'd0, busy}, 32'd0);
      chk("mid-reset way_err", {31'd0, way_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'b1000, 32'h66, 1'b0);
      #1;
      chk("restart fl_ready", {31'd0, fl_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("restart w0 way", {28'd0, wr_target_way}, 32'h8);
      chk("restart w0 data", wr_data, 32'h66);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'b1000, 32'h67, 1'b1);
      @(posedge clk);
      #1;
      chk("restart w1 data", wr_data, 32'h67);
      @(negedge clk);
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      chk("flushed no store way", {28'd0, wr_target_way}, 32'd0);
      chk("flushed busy", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
